shift_add_multiplier: RTL and testbench

//  Parametrised sequential shift-add multiplier core. Replaces the fixed 8-bit lab multiplier datapath.

---
 rtl/shift_add_multiplier.sv | 99 +++++++++
 tb/tb_shift_add_multiplier.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier.sv
// Sequential shift-add multiplier: one ADD/SHIFT pair per multiplier bit, product left in X:A:B.
// SIGNED=1 runs a two's-complement multiply by subtracting the multiplicand on the last bit.
module shift_add_multiplier #(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             ClearA_LoadB,
  input  logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             X,
  output logic             Busy,
  output logic             Done
);
  localparam int KW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [KW-1:0] KLAST = KW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_r, a_nxt, b_r, b_nxt;
  logic             x_r, x_nxt;
  logic [KW-1:0]    k_r, k_nxt;
  logic [WIDTH:0]   a_ext, s_ext, sum;

  // Sign-extended add; the weight of the multiplier's top bit is negative, hence the subtract.
  always_comb begin
    a_ext = SIGNED ? {a_r[WIDTH-1], a_r} : {1'b0, a_r};
    s_ext = SIGNED ? {S[WIDTH-1], S}     : {1'b0, S};
    sum   = (SIGNED && (k_r == KLAST)) ? (a_ext - s_ext) : (a_ext + s_ext);
  end

  always_comb begin
    state_nxt = state;
    a_nxt     = a_r;
    b_nxt     = b_r;
    x_nxt     = x_r;
    k_nxt     = k_r;
    case (state)
      IDLE: begin
        if (ClearA_LoadB) begin
          a_nxt = '0;
          x_nxt = 1'b0;
          b_nxt = S;
        end else if (Run) begin
          a_nxt     = '0;
          x_nxt     = 1'b0;
          k_nxt     = '0;
          state_nxt = ADD;
        end
      end
      ADD: begin
        if (b_r[0]) {x_nxt, a_nxt} = sum;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        b_nxt = {a_r[0], b_r[WIDTH-1:1]};
        a_nxt = {x_r, a_r[WIDTH-1:1]};
        x_nxt = SIGNED ? x_r : 1'b0;
        if (k_r == KLAST) begin
          state_nxt = DONE;
        end else begin
          k_nxt     = k_r + 1'b1;
          state_nxt = ADD;
        end
      end
      DONE: begin
        // Run must drop before another multiply can start.
        if (!Run) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      a_r   <= '0;
      b_r   <= '0;
      x_r   <= 1'b0;
      k_r   <= '0;
    end else begin
      state <= state_nxt;
      a_r   <= a_nxt;
      b_r   <= b_nxt;
      x_r   <= x_nxt;
      k_r   <= k_nxt;
    end
  end

  assign Aval = a_r;
  assign Bval = b_r;
  assign X    = x_r;
  assign Busy = (state == ADD) || (state == SHIFT);
  assign Done = (state == DONE);
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench: three cores (8-bit signed, 8-bit unsigned, 16-bit signed) share control lines;
// products are predicted with plain integer multiplication and checked when Done rises.
module tb_shift_add_multiplier;
  logic        clk = 1'b0;
  logic        rst, run, clr;
  logic [7:0]  s_s8, s_u8;
  logic [15:0] s_s16;
  logic [7:0]  a_s8, b_s8, a_u8, b_u8;
  logic [15:0] a_s16, b_s16;
  logic        x_s8, x_u8, x_s16;
  logic        busy_s8, busy_u8, busy_s16, done_s8, done_u8, done_s16;

  int checks = 0, failures = 0, cyc = 0;

  typedef struct {logic [63:0] val; int start;} exp_t;
  exp_t q_s8[$], q_u8[$], q_s16[$];
  exp_t e_s8, e_u8, e_s16;
  logic [63:0] mb_s8, mb_u8, mb_s16;
  logic dp_s8 = 1'b0, dp_u8 = 1'b0, dp_s16 = 1'b0;

  shift_add_multiplier #(.WIDTH(8), .SIGNED(1'b1)) u_s8 (
    .Clk(clk), .Reset(rst), .Run(run), .ClearA_LoadB(clr), .S(s_s8),
    .Aval(a_s8), .Bval(b_s8), .X(x_s8), .Busy(busy_s8), .Done(done_s8));
  shift_add_multiplier #(.WIDTH(8), .SIGNED(1'b0)) u_u8 (
    .Clk(clk), .Reset(rst), .Run(run), .ClearA_LoadB(clr), .S(s_u8),
    .Aval(a_u8), .Bval(b_u8), .X(x_u8), .Busy(busy_u8), .Done(done_u8));
  shift_add_multiplier #(.WIDTH(16), .SIGNED(1'b1)) u_s16 (
    .Clk(clk), .Reset(rst), .Run(run), .ClearA_LoadB(clr), .S(s_s16),
    .Aval(a_s16), .Bval(b_s16), .X(x_s16), .Busy(busy_s16), .Done(done_s16));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Product as {X, 2w-bit product}; signed operands are reinterpreted from their w-bit patterns.
  function automatic logic [63:0] ref_mul(input logic [63:0] b, input logic [63:0] s,
                                          input int w, input bit sg);
    longint bv, sv, p;
    logic [63:0] pm, m;
    bv = longint'(b);
    sv = longint'(s);
    if (sg && b[w-1]) bv = bv - (longint'(1) << w);
    if (sg && s[w-1]) sv = sv - (longint'(1) << w);
    p  = bv * sv;
    m  = (64'd1 << (2 * w)) - 64'd1;
    pm = 64'(p) & m;
    if (sg && pm[2*w-1]) pm = pm | (64'd1 << (2 * w));
    return pm;
  endfunction

  always @(negedge clk) begin
    if (done_s8 && !dp_s8) begin
      if (q_s8.size() == 0) chk("s8_unexpected_done", 1, 0);
      else begin
        e_s8 = q_s8.pop_front();
        chk("s8_product", {47'd0, x_s8, a_s8, b_s8}, e_s8.val);
        chk("s8_latency", 64'(cyc - e_s8.start), 64'd16);
      end
    end
    dp_s8 <= done_s8;
  end

  always @(negedge clk) begin
    if (done_u8 && !dp_u8) begin
      if (q_u8.size() == 0) chk("u8_unexpected_done", 1, 0);
      else begin
        e_u8 = q_u8.pop_front();
        chk("u8_product", {47'd0, x_u8, a_u8, b_u8}, e_u8.val);
        chk("u8_latency", 64'(cyc - e_u8.start), 64'd16);
      end
    end
    dp_u8 <= done_u8;
  end

  always @(negedge clk) begin
    if (done_s16 && !dp_s16) begin
      if (q_s16.size() == 0) chk("s16_unexpected_done", 1, 0);
      else begin
        e_s16 = q_s16.pop_front();
        chk("s16_product", {31'd0, x_s16, a_s16, b_s16}, e_s16.val);
        chk("s16_latency", 64'(cyc - e_s16.start), 64'd32);
      end
    end
    dp_s16 <= done_s16;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load(input logic [7:0] v8s, input logic [7:0] v8u, input logic [15:0] v16);
    s_s8 = v8s; s_u8 = v8u; s_s16 = v16; clr = 1'b1;
    tick();
    clr = 1'b0;
    mb_s8 = 64'(v8s); mb_u8 = 64'(v8u); mb_s16 = 64'(v16);
    chk("load_s8",  {47'd0, x_s8, a_s8, b_s8},    mb_s8);
    chk("load_u8",  {47'd0, x_u8, a_u8, b_u8},    mb_u8);
    chk("load_s16", {31'd0, x_s16, a_s16, b_s16}, mb_s16);
  endtask

  task automatic mul(input logic [7:0] v8s, input logic [7:0] v8u, input logic [15:0] v16,
                     input int hold, input bit clr_mid);
    logic [63:0] r;
    exp_t e;
    int n;
    s_s8 = v8s; s_u8 = v8u; s_s16 = v16; run = 1'b1;
    e.start = cyc + 1;
    r = ref_mul(mb_s8, 64'(v8s), 8, 1'b1);   e.val = r; q_s8.push_back(e);  mb_s8  = r & 64'hFF;
    r = ref_mul(mb_u8, 64'(v8u), 8, 1'b0);   e.val = r; q_u8.push_back(e);  mb_u8  = r & 64'hFF;
    r = ref_mul(mb_s16, 64'(v16), 16, 1'b1); e.val = r; q_s16.push_back(e); mb_s16 = r & 64'hFFFF;
    n = 0;
    while (!(done_s8 && done_u8 && done_s16) && n < 100) begin
      tick();
      n++;
      clr = clr_mid && (n == 4);
    end
    clr = 1'b0;
    chk("mul_done", {61'd0, done_s8, done_u8, done_s16}, 64'd7);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("held_run_done", {61'd0, done_s8, done_u8, done_s16}, 64'd7);
    end
    run = 1'b0;
    tick();
    chk("idle_after_run_low", {58'd0, busy_s8, busy_u8, busy_s16, done_s8, done_u8, done_s16}, 64'd0);
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; clr = 1'b0; s_s8 = '0; s_u8 = '0; s_s16 = '0;
    mb_s8 = '0; mb_u8 = '0; mb_s16 = '0;
    repeat (3) tick();
    rst = 1'b0;
    chk("reset_state", {a_s8, b_s8, a_u8, b_u8, x_s8, x_u8, busy_s8, busy_u8, done_s8, done_u8}, 64'd0);
    chk("reset_state_s16", {a_s16, b_s16, x_s16, busy_s16, done_s16}, 64'd0);

    load(8'h07, 8'h07, 16'h0007);
    mul(8'h03, 8'h03, 16'h0003, 0, 1'b0);
    chk("spec_3x7", {47'd0, x_s8, a_s8, b_s8}, 64'h0015);

    load(8'h03, 8'h03, 16'h0003);
    mul(8'hF9, 8'hF9, 16'hFFF9, 0, 1'b0);
    chk("spec_3xm7", {47'd0, x_s8, a_s8, b_s8}, 64'h1FFEB);
    mul(8'h02, 8'h02, 16'h0002, 0, 1'b0);
    chk("spec_consecutive", {48'd0, a_s8, b_s8}, 64'hFFD6);

    load(8'h80, 8'hFF, 16'h8000);
    mul(8'h80, 8'hFF, 16'h0003, 0, 1'b0);
    chk("spec_min_sq", {47'd0, x_s8, a_s8, b_s8}, 64'h04000);
    chk("spec_ff_sq",  {47'd0, x_u8, a_u8, b_u8}, 64'h0FE01);
    chk("spec_w16",    {31'd0, x_s16, a_s16, b_s16}, 64'h1FFFE8000);

    load(8'($urandom), 8'($urandom), 16'($urandom));
    mul(8'($urandom), 8'($urandom), 16'($urandom), 20, 1'b0);

    load(8'($urandom), 8'($urandom), 16'($urandom));
    mul(8'($urandom), 8'($urandom), 16'($urandom), 0, 1'b1);

    // Reset in the middle of a multiply throws the partial result away.
    s_s8 = 8'h5A; s_u8 = 8'hA5; s_s16 = 16'h1234; run = 1'b1;
    repeat (5) tick();
    rst = 1'b1; run = 1'b0;
    tick();
    rst = 1'b0;
    chk("mid_reset", {a_s8, b_s8, a_u8, b_u8, x_s8, x_u8, busy_s8, busy_u8, done_s8, done_u8}, 64'd0);
    chk("mid_reset_s16", {a_s16, b_s16, x_s16, busy_s16, done_s16}, 64'd0);
    mb_s8 = '0; mb_u8 = '0; mb_s16 = '0;

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(2) != 0) load(8'($urandom), 8'($urandom), 16'($urandom));
      mul(8'($urandom), 8'($urandom), 16'($urandom), int'($urandom_range(2)), 1'($urandom_range(1)));
    end

    repeat (3) tick();
    chk("scoreboard_drained", 64'(q_s8.size() + q_u8.size() + q_s16.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
